// File: rtl/uart_tx_sched.sv
// Two-source byte scheduler feeding a single UART TX serializer.
// Define UART_TX_SCHED_RR_EN for round-robin arbitration (default: RD over ALU).
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RD_DATA,
  input  logic                      RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      TX_BUSY,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  output logic                      SCHED_BUSY,
  output logic                      OVERRUN
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic SRC_RD  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

  logic [1:0]              state_q, state_d;
  logic                    pend_rd_q, pend_rd_d;
  logic                    pend_alu_q, pend_alu_d;
  logic [DATA_WIDTH-1:0]   hold_rd_q, hold_rd_d;
  logic [2*DATA_WIDTH-1:0] hold_alu_q, hold_alu_d;
  logic [2*DATA_WIDTH-1:0] work_q, work_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    src_q, src_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;

  logic is_idle;
  logic pick_alu;
  logic grant_rd;
  logic grant_alu;
  logic ovr_rd;
  logic ovr_alu;

  assign is_idle = (state_q == IDLE);

`ifdef UART_TX_SCHED_RR_EN
  // On contention, hand the slot to whoever did not go last
  assign pick_alu = pend_alu_q & (~pend_rd_q | (last_q == SRC_RD));
`else
  assign pick_alu = pend_alu_q & ~pend_rd_q;
`endif

  assign grant_alu = is_idle & pick_alu;
  assign grant_rd  = is_idle & pend_rd_q & ~pick_alu;

  // A strobe on the grant cycle refills the slot being vacated
  assign ovr_rd  = RD_DATA_VLD & pend_rd_q & ~grant_rd;
  assign ovr_alu = ALU_OUT_VLD & pend_alu_q & ~grant_alu;

  always_comb begin
    pend_rd_d  = pend_rd_q;
    hold_rd_d  = hold_rd_q;
    pend_alu_d = pend_alu_q;
    hold_alu_d = hold_alu_q;

    if (RD_DATA_VLD & ~ovr_rd) begin
      pend_rd_d = 1'b1;
      hold_rd_d = RD_DATA;
    end else if (grant_rd) begin
      pend_rd_d = 1'b0;
    end

    if (ALU_OUT_VLD & ~ovr_alu) begin
      pend_alu_d = 1'b1;
      hold_alu_d = ALU_OUT;
    end else if (grant_alu) begin
      pend_alu_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    last_d  = last_q;
    txd_d   = txd_q;

    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          work_d  = {{DATA_WIDTH{1'b0}}, hold_rd_q};
          txd_d   = hold_rd_q;
          cnt_d   = 2'd1;
          src_d   = SRC_RD;
          state_d = LOAD;
        end else if (grant_alu) begin
          work_d  = hold_alu_q;
          txd_d   = hold_alu_q[DATA_WIDTH-1:0];
          cnt_d   = 2'd2;
          src_d   = SRC_ALU;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (TX_BUSY) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d != 2'd0) begin
            txd_d   = work_q[2*DATA_WIDTH-1:DATA_WIDTH];
            state_d = LOAD;
          end else begin
            last_d  = src_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      pend_rd_q  <= 1'b0;
      pend_alu_q <= 1'b0;
      hold_rd_q  <= '0;
      hold_alu_q <= '0;
      work_q     <= '0;
      cnt_q      <= 2'd0;
      src_q      <= SRC_RD;
      last_q     <= SRC_RD;
      txd_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_alu_q <= pend_alu_d;
      hold_rd_q  <= hold_rd_d;
      hold_alu_q <= hold_alu_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
    end
  end

  assign TX_P_DATA  = txd_q;
  assign TX_D_VLD   = (state_q == LOAD);
  assign SCHED_BUSY = ~is_idle | pend_rd_q | pend_alu_q;
  assign OVERRUN    = ovr_rd | ovr_alu;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a request/byte-queue model.
// Honours UART_TX_SCHED_RR_EN the same way as the design.
module tb_uart_tx_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RD_DATA;
  logic        RD_DATA_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        SCHED_BUSY;
  logic        OVERRUN;

  uart_tx_sched #(.DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RD_DATA     (RD_DATA),
    .RD_DATA_VLD (RD_DATA_VLD),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_BUSY     (TX_BUSY),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .SCHED_BUSY  (SCHED_BUSY),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: pending requests, expected byte stream, TX emulator
  bit          mdl_en;
  bit          m_idle;
  bit          m_prd;
  bit          m_palu;
  bit          m_last;
  bit          m_src;
  bit          m_vld_nxt;
  bit          prev_busy;
  logic [7:0]  m_hrd;
  logic [15:0] m_halu;
  logic [7:0]  m_txd;
  int          m_left;
  logic [7:0]  exp_q[$];
  int          em_pre;
  int          em_hi;
  logic        busy_nxt;
  int          n_bytes = 0;

  always @(negedge CLK) begin
    bit g_rd;
    bit g_alu;
    bit ovr;
    bit nidle;
    bit nvld;
    if (!mdl_en) begin
      m_idle    = 1'b1;
      m_prd     = 1'b0;
      m_palu    = 1'b0;
      m_last    = 1'b0;
      m_src     = 1'b0;
      m_vld_nxt = 1'b0;
      prev_busy = 1'b0;
      m_hrd     = '0;
      m_halu    = '0;
      m_txd     = '0;
      m_left    = 0;
      exp_q.delete();
      em_pre    = 0;
      em_hi     = 0;
      busy_nxt  = 1'b0;
    end else begin
      chk("vld", 32'(TX_D_VLD), 32'(m_vld_nxt));
      if (m_vld_nxt && exp_q.size() > 0) m_txd = exp_q.pop_front();
      chk("txd", 32'(TX_P_DATA), 32'(m_txd));
      chk("sbusy", 32'(SCHED_BUSY), 32'(!m_idle || m_prd || m_palu));

`ifdef UART_TX_SCHED_RR_EN
      g_alu = m_idle && m_palu && (!m_prd || !m_last);
`else
      g_alu = m_idle && m_palu && !m_prd;
`endif
      g_rd  = m_idle && m_prd && !g_alu;

      nidle = m_idle;
      nvld  = 1'b0;
      if (g_rd || g_alu) begin
        nidle = 1'b0;
        nvld  = 1'b1;
        m_src = g_alu;
        if (g_alu) begin
          exp_q.push_back(m_halu[7:0]);
          exp_q.push_back(m_halu[15:8]);
          m_left = 2;
        end else begin
          exp_q.push_back(m_hrd);
          m_left = 1;
        end
      end

      ovr = 1'b0;
      if (RD_DATA_VLD) begin
        if (!m_prd || g_rd) begin
          m_prd = 1'b1;
          m_hrd = RD_DATA;
        end else ovr = 1'b1;
      end else if (g_rd) m_prd = 1'b0;
      if (ALU_OUT_VLD) begin
        if (!m_palu || g_alu) begin
          m_palu = 1'b1;
          m_halu = ALU_OUT;
        end else ovr = 1'b1;
      end else if (g_alu) m_palu = 1'b0;
      chk("ovr", 32'(OVERRUN), 32'(ovr));

      // Each busy fall retires one byte of the transfer in service
      if (prev_busy && !TX_BUSY) begin
        m_left--;
        if (m_left > 0) nvld = 1'b1;
        else begin
          nidle  = 1'b1;
          m_last = m_src;
        end
      end
      prev_busy = TX_BUSY;
      m_idle    = nidle;
      m_vld_nxt = nvld;

      if (TX_D_VLD) begin
        em_pre = int'($urandom_range(0, 3));
        em_hi  = int'($urandom_range(1, 6));
        n_bytes++;
      end
      if (em_pre > 0) begin
        em_pre--;
        busy_nxt = 1'b0;
      end else if (em_hi > 0) begin
        em_hi--;
        busy_nxt = 1'b1;
      end else busy_nxt = 1'b0;
    end
  end

  initial begin
    bit hit;
    int nv;
    RST         = 1'b0;
    mdl_en      = 1'b0;
    RD_DATA     = '0;
    RD_DATA_VLD = 1'b0;
    ALU_OUT     = '0;
    ALU_OUT_VLD = 1'b0;
    TX_BUSY     = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_vld", 32'(TX_D_VLD), 32'(0));
    chk("rst_txd", 32'(TX_P_DATA), 32'(0));
    chk("rst_sbusy", 32'(SCHED_BUSY), 32'(0));
    chk("rst_ovr", 32'(OVERRUN), 32'(0));
    RST    = 1'b1;
    mdl_en = 1'b1;

    for (int k = 0; k < 3200; k++) begin
      @(posedge CLK);
      #1;
      TX_BUSY     = busy_nxt;
      RD_DATA     = 8'($urandom);
      ALU_OUT     = 16'($urandom);
      RD_DATA_VLD = 1'b0;
      ALU_OUT_VLD = 1'b0;
      if (k < 150) begin
        case (k)
          2: begin
            RD_DATA = 8'h55; RD_DATA_VLD = 1'b1;
            ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
          end
          60:  begin RD_DATA = 8'hA5; RD_DATA_VLD = 1'b1; end
          100: begin ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1; end
          default: ;
        endcase
      end else if (k < 3000) begin
        RD_DATA_VLD = ($urandom_range(0, 5) == 0);
        ALU_OUT_VLD = ($urandom_range(0, 7) == 0);
      end
    end
    chk("drained", 32'(SCHED_BUSY), 32'(0));
    chk("bytes_seen", 32'(n_bytes > 20), 32'(1));

    // Abort an ALU transfer while its low byte is in WAIT_LO
    @(posedge CLK);
    #1;
    ALU_OUT     = 16'hCAFE;
    ALU_OUT_VLD = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      ALU_OUT_VLD = 1'b0;
      if (TX_D_VLD) begin
        hit = 1'b1;
        break;
      end
    end
    chk("lsb_vld", 32'(hit), 32'(1));
    chk("lsb_data", 32'(TX_P_DATA), 32'h0FE);
    repeat (3) begin
      @(posedge CLK);
      #1;
      TX_BUSY = 1'b1;
    end
    #2;
    RST    = 1'b0;
    mdl_en = 1'b0;
    #1;
    chk("abort_vld", 32'(TX_D_VLD), 32'(0));
    chk("abort_txd", 32'(TX_P_DATA), 32'(0));
    chk("abort_sbusy", 32'(SCHED_BUSY), 32'(0));
    chk("abort_ovr", 32'(OVERRUN), 32'(0));
    TX_BUSY = 1'b0;
    @(posedge CLK);
    #1;
    RST    = 1'b1;
    mdl_en = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      TX_BUSY = busy_nxt;
      if (TX_D_VLD) nv++;
    end
    chk("post_rst_vld", 32'(nv), 32'(0));
    chk("post_rst_sbusy", 32'(SCHED_BUSY), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Scheduler sitting in front of the UART transmitter; shares the single TX serializer between two requesters: register-file read data (1 byte) and ALU result (2 bytes).
- Latches single-cycle valid strobes from each source, arbitrates between them, and feeds bytes to the TX one frame at a time.
- Each frame is handed off as a one-cycle data-valid pulse; the block then tracks TX busy rise and fall before issuing the next byte.
- Lives in the main clock domain; TX_BUSY arrives already synchronized to CLK.

Parameters:
- DATA_WIDTH, 8, width of one UART frame payload; ALU result is 2*DATA_WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- RD_DATA  input  DATA_WIDTH  register-file read data.
- RD_DATA_VLD  input  1  one-cycle strobe, RD_DATA valid.
- ALU_OUT  input  2*DATA_WIDTH  ALU result.
- ALU_OUT_VLD  input  1  one-cycle strobe, ALU_OUT valid.
- TX_BUSY  input  1  UART TX busy, synchronous to CLK.
- TX_P_DATA  output  DATA_WIDTH  byte presented to the TX.
- TX_D_VLD  output  1  one-cycle pulse, TX_P_DATA valid.
- SCHED_BUSY  output  1  high while any request is pending or in service.
- OVERRUN  output  1  one-cycle pulse, a strobe was dropped.

Behaviour:
- Reset (RST low, async):
  - All outputs 0; TX_P_DATA = 0.
  - Pending flags cleared; state IDLE; byte counter 0; last-grant = RD.
- Request capture, every cycle:
  - A source strobe with its pending flag clear copies the data into that source's holding register and sets the flag.
  - A strobe while the flag is already set is dropped: holding register unchanged, OVERRUN = 1 for that cycle.
  - Both strobes in the same cycle are both captured.
- FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - If any flag is set, grant per the arbitration rule.
  - On grant: copy the granted holding register to the work register, clear the granted flag, and set byte count to 1 (RD) or 2 (ALU).
  - Go to LOAD on the next cycle.
  - A strobe arriving on the grant cycle from the granted source re-sets its flag with the new data; this is not an overrun.
- LOAD:
  - TX_D_VLD = 1 for exactly one cycle.
  - TX_P_DATA = current byte: work[7:0] first, then work[15:8] for ALU.
  - Next state WAIT_HI.
- WAIT_HI:
  - Hold TX_P_DATA stable; TX_D_VLD = 0.
  - Stay until TX_BUSY = 1, then go to WAIT_LO.
  - If TX_BUSY is already high in LOAD, WAIT_HI exits on its first cycle.
- WAIT_LO:
  - Stay until TX_BUSY = 0.
  - Then decrement byte count.
  - Count nonzero: go to LOAD with the upper byte.
  - Count zero: go to IDLE and update last-grant.
- Arbitration (default build): fixed priority, RD over ALU.
- ALU transfers are atomic: no RD byte is inserted between the LSB and MSB bytes.
- SCHED_BUSY = (state != IDLE) | pending_rd | pending_alu.
- Minimum latency: strobe at cycle N → capture at N+1 → IDLE grant → TX_D_VLD at N+2.
- TX_P_DATA retains its last value in IDLE.
- Reset mid-transfer aborts immediately: the partial ALU frame is not completed and pending requests are lost.

Optional Feature:
- Macro: UART_TX_SCHED_RR_EN.
- Defined: round-robin arbitration. When both flags are set in IDLE, grant the source not equal to last-grant; a single pending source is granted regardless.
- Undefined: fixed priority, RD over ALU, as above. last-grant is still tracked but unused.

Test Plan:
- Single RD: RD_DATA=0xA5 strobe, TX_BUSY pulled high 2 cycles after TX_D_VLD and held 10 cycles → one TX_D_VLD with 0xA5; SCHED_BUSY falls the cycle after TX_BUSY falls.
- Single ALU: ALU_OUT=0x1234 strobe → TX_D_VLD with 0x34, then after a full busy cycle a second TX_D_VLD with 0x12; exactly 2 pulses.
- Simultaneous: RD=0x55 and ALU=0xBEEF in the same cycle, default build → byte order 0x55, 0xEF, 0xBE.
  - With UART_TX_SCHED_RR_EN and last-grant=RD: order 0xEF, 0xBE, 0x55.
- Overrun: RD=0x11 strobe, then RD=0x22 strobe while 0x11 is in WAIT_HI and the RD flag is clear, then RD=0x33 strobe while 0x22 is pending → OVERRUN pulses once; bytes sent are 0x11, 0x22 only.
- Atomicity: ALU=0xCAFE in service; RD=0x77 strobe during WAIT_LO of byte 0xFE → sequence 0xFE, 0xCA, 0x77.
- Reset mid-frame: assert RST during WAIT_LO of ALU LSB → all outputs 0 asynchronously; after release, no MSB byte is sent and SCHED_BUSY = 0.
